// File: rtl/dram_responder.sv
// dram_responder: line-granular backing memory answering cache-controller requests
// after a fixed access latency with a one-cycle acknowledge.
module dram_responder #(
    parameter int LATENCY   = 10,
    parameter int LINE_BITS = 256,
    parameter int DEPTH     = 512
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [31:0]          addr_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o,
    output logic                 busy_o
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t               state, state_nx;
    logic [7:0]           cnt;
    logic [IW-1:0]        idx;
    logic                 wr;
    logic [LINE_BITS-1:0] wdata;
    logic [LINE_BITS-1:0] memory [0:DEPTH-1];
    logic                 done;
    logic                 accept;
    logic                 unused_addr;

    assign unused_addr = ^{addr_i[31:IW+5], addr_i[4:0]};
    assign accept      = state == IDLE && enable_i;
    assign done        = state == BUSY && cnt == 8'd0;
    assign ack_o       = state == ACK;
    assign busy_o      = state != IDLE;

    // ACK always returns to IDLE so a held enable cannot re-trigger on the ack edge
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = enable_i ? BUSY : IDLE;
            BUSY:    state_nx = cnt == 8'd0 ? ACK : BUSY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            idx    <= '0;
            wr     <= 1'b0;
            wdata  <= '0;
            data_o <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                idx   <= addr_i[IW+4:5];
                wr    <= write_i;
                wdata <= data_i;
                cnt   <= 8'(LATENCY - 1);
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (done && !wr)
                data_o <= memory[idx];
        end
    end

    // Storage has no reset; an async reset leaves BUSY before the commit edge
    always_ff @(posedge clk_i) begin
        if (done && wr)
            memory[idx] <= wdata;
    end
endmodule

// File: tb/tb_dram_responder.sv
// tb_dram_responder: directed checks of latency, ack pulse, held enable, input
// isolation, reset abort and the LATENCY=1 / index-wrap corner.
module tb_dram_responder;
    logic         clk;
    logic         rst_n;
    logic         en, en1, wr;
    logic [31:0]  addr;
    logic [255:0] din;
    logic         ack, ack1, busy, busy1;
    logic [255:0] dout, dout1;
    int           total = 0;
    int           bad = 0;

    localparam logic [255:0] PAT_A5 = {32{8'hA5}};
    localparam logic [255:0] PAT_Q  = {8{32'h0BAD_F00D}};
    localparam logic [255:0] X1     = {8{32'h1111_0001}};
    localparam logic [255:0] X2     = {8{32'h2222_0002}};
    localparam logic [255:0] OLD5   = {8{32'h5555_AAAA}};
    localparam logic [255:0] P0     = {8{32'hC0DE_0000}};

    dram_responder #(.LATENCY(10), .LINE_BITS(256), .DEPTH(512)) dut (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en), .write_i(wr), .addr_i(addr),
        .data_i(din), .ack_o(ack), .data_o(dout), .busy_o(busy)
    );

    dram_responder #(.LATENCY(1), .LINE_BITS(256), .DEPTH(512)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .enable_i(en1), .write_i(wr), .addr_i(addr),
        .data_i(din), .ack_o(ack1), .data_o(dout1), .busy_o(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic start(input logic w, input logic [31:0] a, input logic [255:0] d);
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; din = d;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_idle busy=%b required=0 after 60 cycles", busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; en1 = 1'b0; wr = 1'b0; addr = '0; din = '0;
        repeat (2) @(negedge clk);
        total += 3;
        if (ack !== 1'b0)  begin bad++; $display("FAIL reset_ack got=%b exp=0", ack); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (dout !== '0)   begin bad++; $display("FAIL reset_data got=%h exp=0", dout); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        dut.memory[3] = PAT_A5;
        start(1'b0, 32'h60, '0);
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            if (c == 0) en = 1'b0;
            total += 2;
            if (ack !== (c == 10)) begin bad++; $display("FAIL read_ack c=%0d got=%b exp=%b", c, ack, c == 10); end
            if (busy !== (c <= 10)) begin bad++; $display("FAIL read_busy c=%0d got=%b exp=%b", c, busy, c <= 10); end
            if (c >= 10) begin
                total++;
                if (dout !== PAT_A5) begin bad++; $display("FAIL read_data c=%0d got=%h exp=%h", c, dout, PAT_A5); end
            end
        end
    endtask

    task automatic test_write_read();
        start(1'b1, 32'h80, 256'h1234);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 0) en = 1'b0;
            total++;
            if (ack !== (c == 10)) begin bad++; $display("FAIL wr_ack c=%0d got=%b exp=%b", c, ack, c == 10); end
            if (c == 10) begin
                total += 2;
                if (dout !== PAT_A5) begin bad++; $display("FAIL wr_data_hold got=%h exp=%h", dout, PAT_A5); end
                if (dut.memory[4] !== 256'h1234) begin bad++; $display("FAIL wr_mem got=%h exp=1234", dut.memory[4]); end
            end
        end
        start(1'b0, 32'h80, '0);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 0) en = 1'b0;
            total++;
            if (ack !== (c == 10)) begin bad++; $display("FAIL rd_ack c=%0d got=%b exp=%b", c, ack, c == 10); end
            if (c == 10) begin
                total++;
                if (dout !== 256'h1234) begin bad++; $display("FAIL rd_data got=%h exp=1234", dout); end
            end
        end
    endtask

    task automatic test_back_to_back();
        dut.memory[0] = PAT_Q;
        start(1'b0, 32'h0, '0);
        for (int c = 0; c <= 39; c++) begin
            @(negedge clk);
            total++;
            if (ack !== (c == 10 || c == 22 || c == 34)) begin
                bad++;
                $display("FAIL held_ack c=%0d got=%b exp=%b", c, ack, c == 10 || c == 22 || c == 34);
            end
        end
        en = 1'b0;
        total++;
        if (dout !== PAT_Q) begin bad++; $display("FAIL held_data got=%h exp=%h", dout, PAT_Q); end
        wait_idle();
    endtask

    task automatic test_mid_change();
        dut.memory[1] = X1;
        dut.memory[2] = X2;
        start(1'b0, 32'h20, '0);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 0) en = 1'b0;
            if (c == 3) begin addr = 32'h40; wr = 1'b1; din = '1; end
            total++;
            if (ack !== (c == 10)) begin bad++; $display("FAIL mid_ack c=%0d got=%b exp=%b", c, ack, c == 10); end
            if (c == 10) begin
                total += 2;
                if (dout !== X1) begin bad++; $display("FAIL mid_data got=%h exp=%h", dout, X1); end
                if (dut.memory[2] !== X2) begin bad++; $display("FAIL mid_mem2 got=%h exp=%h", dut.memory[2], X2); end
            end
        end
        wr = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        dut.memory[5] = OLD5;
        start(1'b1, 32'hA0, 256'hFF);
        for (int c = 0; c <= 5; c++) begin
            @(negedge clk);
            if (c == 0) en = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
        if (dout !== '0)   begin bad++; $display("FAIL rst_data got=%h exp=0", dout); end
        if (ack !== 1'b0)  begin bad++; $display("FAIL rst_ack got=%b exp=0", ack); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            total++;
            if (ack !== 1'b0) begin bad++; $display("FAIL rst_noack c=%0d got=%b exp=0", c, ack); end
        end
        total++;
        if (dut.memory[5] !== OLD5) begin bad++; $display("FAIL rst_mem got=%h exp=%h", dut.memory[5], OLD5); end
        start(1'b0, 32'hA0, '0);
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 0) en = 1'b0;
            total++;
            if (ack !== (c == 10)) begin bad++; $display("FAIL rst_rd_ack c=%0d got=%b exp=%b", c, ack, c == 10); end
            if (c == 10) begin
                total++;
                if (dout !== OLD5) begin bad++; $display("FAIL rst_rd_data got=%h exp=%h", dout, OLD5); end
            end
        end
    endtask

    task automatic test_min_latency();
        dut1.memory[0] = P0;
        @(negedge clk);
        en1 = 1'b1; wr = 1'b0; addr = 32'h4000;
        for (int c = 0; c <= 3; c++) begin
            @(negedge clk);
            if (c == 0) en1 = 1'b0;
            total += 2;
            if (ack1 !== (c == 1)) begin bad++; $display("FAIL lat1_ack c=%0d got=%b exp=%b", c, ack1, c == 1); end
            if (busy1 !== (c <= 1)) begin bad++; $display("FAIL lat1_busy c=%0d got=%b exp=%b", c, busy1, c <= 1); end
            if (c >= 1) begin
                total++;
                if (dout1 !== P0) begin bad++; $display("FAIL lat1_data c=%0d got=%h exp=%h", c, dout1, P0); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_back_to_back();
        test_mid_change();
        test_reset_mid_write();
        test_min_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dram_responder.md
# dram_responder

Responder end of the cache-controller-to-memory interface. It accepts one 256-bit line request at a time from the data cache controller, models a fixed off-chip access latency, and returns a one-cycle acknowledge with read data held stable afterwards. It sits beneath the cache controller in the CPU top level and owns the backing line storage.

## Interface

**Parameters**
- LATENCY, 10: cycles from request acceptance to `ack_o`; legal range 1..255.
- LINE_BITS, 256: line width in bits.
- DEPTH, 512: number of lines in the backing array.

**Ports**
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `enable_i`, in, 1: request valid from the cache controller.
- `write_i`, in, 1: 1 = line write, 0 = line read; sampled with `enable_i`.
- `addr_i`, in, 32: byte address.
  - Line index = `addr_i[4+log2(DEPTH):5]`.
  - `addr_i[4:0]` and the upper bits are ignored.
- `data_i`, in, LINE_BITS: write line; sampled with `enable_i`.
- `ack_o`, out, 1: request complete; high for exactly one cycle.
- `data_o`, out, LINE_BITS: read line; valid from the `ack_o` cycle until the next read ack.
- `busy_o`, out, 1: high while a request is outstanding (BUSY or ACK state).

## Operation

**Storage**
- Array `memory[0:DEPTH-1]` of LINE_BITS.
- Not cleared by reset; the bench preloads it hierarchically.

**States**
- IDLE
  - If `enable_i`=1: latch the line index, `write_i` and `data_i`; load the counter with LATENCY-1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY
  - If counter != 0: decrement and stay.
  - If counter == 0: go to ACK.
    - On a read, load `data_o` with `memory[latched index]`.
    - On a write, store the latched data into `memory[latched index]`; `data_o` is unchanged.
- ACK
  - `ack_o`=1.
  - Go to IDLE unconditionally at the next edge, regardless of `enable_i`.

**Input sampling rules**
- All request inputs are ignored in BUSY and ACK. Changes to `addr_i`, `data_i` or `write_i` mid-request have no effect.
- The controller keeps `enable_i` high through the ACK cycle. That edge must not start a new request.
- A new request is accepted no earlier than the first edge spent in IDLE after ACK.

**Outputs**
- `ack_o` and `busy_o` are decoded from the registered state; they have no combinational path from inputs.

**Reset**
- Asynchronous on `rst_i`=0: state = IDLE, counter = 0, `ack_o`=0, `busy_o`=0, `data_o`=0.
- Reset during BUSY aborts the request: no write is committed and no ack is issued.
- Reset during ACK drops `ack_o` immediately.

## Timing

- Request accepted at edge t (IDLE, `enable_i`=1).
- `busy_o` is high from edge t to edge t+LATENCY+1.
- `ack_o` is high from edge t+LATENCY to edge t+LATENCY+1.
- The write is visible in `memory` from edge t+LATENCY.
- Read `data_o` is valid from edge t+LATENCY.
- Minimum spacing between acceptances is LATENCY+2 edges.
  - With LATENCY=10, back-to-back requests with `enable_i` held high are accepted at t and t+12.
- LATENCY=1: accept at t, ack during cycle t+1.
- Write followed by a read to the same line returns the written data. No forwarding is needed because the write commits before ACK.

## Test plan

1. **Read.** Preload `memory[3]`=256'hA5...A5 (repeating). Pulse `enable_i`=1, `write_i`=0, `addr_i`=32'h60 at edge 0.
   - `ack_o`=1 only in cycle 10.
   - `data_o`=A5 pattern from edge 10, held through cycle 30.
2. **Write then read.** Write 256'h1234 to `addr_i`=32'h80, then read 32'h80.
   - Write ack arrives 10 cycles after acceptance and `memory[4]`=256'h1234.
   - Read `data_o`=256'h1234.
   - `data_o` is unchanged during the write ack.
3. **Enable held high.** Hold `enable_i`=1 for 40 cycles with a read to 32'h0.
   - Acks occur in cycles 10, 22 and 34 only.
   - Exactly one ack per 12 cycles; no ack in the cycle after any ack.
4. **Mid-request input changes.** Accept a read of 32'h20, then change `addr_i` to 32'h40 in cycle 3.
   - Returned data is `memory[1]`, not `memory[2]`.
5. **Reset mid-write.** Accept a write of 256'hFF to 32'hA0, then assert `rst_i`=0 in cycle 5 for 2 cycles.
   - `ack_o` never rises.
   - `memory[5]` keeps its old value.
   - `busy_o`=0 and `data_o`=0 immediately on reset.
   - A subsequent read of 32'hA0 acks 10 cycles after acceptance.
6. **Minimum latency and wrap.** Set LATENCY=1; read `addr_i`=32'h4000.
   - With DEPTH=512, the index wraps to line 0.
   - `ack_o` is high in cycle 1.
   - `data_o`=`memory[0]`.
